// File: rtl/decryption_dispatcher.sv
// Front-end sequencer for the Caesar/Scytale/Zigzag engines.
// Routes one message to the selected engine and muxes its plaintext back.
module decryption_dispatcher #(
   parameter int D_WIDTH = 8,
   parameter int KEY_WIDTH = 16,
   parameter int MAX_NOF_CHARS = 50,
   parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 'hFA,
   parameter int START_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [D_WIDTH-1:0]     data_i,
   input  logic                   valid_i,
   input  logic [1:0]             sel_i,
   input  logic [KEY_WIDTH-1:0]   key_i,
   output logic                   ready_o,
   output logic [D_WIDTH-1:0]     eng_data_o,
   output logic [2:0]             eng_valid_o,
   output logic [KEY_WIDTH-1:0]   eng_key_o,
   input  logic [2:0]             eng_busy_i,
   input  logic [3*D_WIDTH-1:0]   eng_data_i,
   input  logic [2:0]             eng_valid_i,
   output logic [D_WIDTH-1:0]     data_o,
   output logic                   valid_o,
   output logic                   busy_o,
   output logic                   err_o
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT_START,
      DECRYPT
   } state_t;

   localparam logic [5:0] MAX_CNT  = 6'(MAX_NOF_CHARS);
   localparam logic [7:0] TMO_LAST = 8'(START_TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [1:0]           sel_q, sel_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [7:0]           tmo_q, tmo_d;
   logic [D_WIDTH-1:0]   eng_data_d;
   logic [2:0]           eng_valid_d;
   logic [D_WIDTH-1:0]   data_d;
   logic                 valid_d;
   logic                 err_fsm;
   logic                 err_mux;

   logic [2:0]           sel_oh;
   logic                 is_tok;
   logic                 full;
   logic                 sel_busy;

   assign sel_oh    = 3'b001 << sel_q;
   assign is_tok    = (data_i == START_DECRYPTION_TOKEN);
   assign full      = (cnt_q == MAX_CNT);
   assign sel_busy  = |(eng_busy_i & sel_oh);

   // Input is only taken while collecting a message and not injecting a token.
   assign ready_o   = (state_q == IDLE) || ((state_q == LOAD) && !full);
   assign busy_o    = (state_q != IDLE);
   assign eng_key_o = key_q;

   // Next-state, latching and engine-side strobe generation.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      key_d       = key_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      eng_data_d  = eng_data_o;
      eng_valid_d = 3'b000;
      err_fsm     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (valid_i) begin
               if (sel_i == 2'd3) begin
                  err_fsm = 1'b1;
               end else begin
                  sel_d       = sel_i;
                  key_d       = key_i;
                  eng_data_d  = data_i;
                  eng_valid_d = 3'b001 << sel_i;
                  tmo_d       = 8'd0;
                  cnt_d       = is_tok ? 6'd0 : 6'd1;
                  state_d     = is_tok ? WAIT_START : LOAD;
               end
            end
         end
         LOAD: begin
            if (full) begin
               eng_data_d  = START_DECRYPTION_TOKEN;
               eng_valid_d = sel_oh;
               tmo_d       = 8'd0;
               state_d     = WAIT_START;
            end else if (valid_i) begin
               eng_data_d  = data_i;
               eng_valid_d = sel_oh;
               if (is_tok) begin
                  tmo_d   = 8'd0;
                  state_d = WAIT_START;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         WAIT_START: begin
            if (sel_busy) begin
               state_d = DECRYPT;
            end else if (tmo_q == TMO_LAST) begin
               err_fsm = 1'b1;
               cnt_d   = 6'd0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         DECRYPT: begin
            if (!sel_busy) begin
               cnt_d   = 6'd0;
               state_d = IDLE;
            end
         end
      endcase
   end

   // Plaintext mux from the latched engine; strays from others flag an error.
   always_comb begin
      data_d  = data_o;
      valid_d = 1'b0;
      err_mux = |(eng_valid_i & ~sel_oh);
      if (|(eng_valid_i & sel_oh)) begin
         valid_d = 1'b1;
         case (sel_q)
            2'd1:    data_d = eng_data_i[D_WIDTH +: D_WIDTH];
            2'd2:    data_d = eng_data_i[2*D_WIDTH +: D_WIDTH];
            default: data_d = eng_data_i[0 +: D_WIDTH];
         endcase
      end
   end

   // State, message context and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= 2'd0;
         key_q       <= '0;
         cnt_q       <= 6'd0;
         tmo_q       <= 8'd0;
         eng_data_o  <= '0;
         eng_valid_o <= 3'b000;
         data_o      <= '0;
         valid_o     <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         key_q       <= key_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         eng_data_o  <= eng_data_d;
         eng_valid_o <= eng_valid_d;
         data_o      <= data_d;
         valid_o     <= valid_d;
         err_o       <= err_fsm | err_mux;
      end
   end

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Bench for decryption_dispatcher: vector tables for messages,
// scoreboards for engine strobes, plaintext and error pulses.
module tb_decryption_dispatcher;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  data_i;
   logic        valid_i;
   logic [1:0]  sel_i;
   logic [15:0] key_i;
   logic        ready_o;
   logic [7:0]  eng_data_o;
   logic [2:0]  eng_valid_o;
   logic [15:0] eng_key_o;
   logic [2:0]  eng_busy_i;
   logic [23:0] eng_data_i;
   logic [2:0]  eng_valid_i;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        busy_o;
   logic        err_o;

   decryption_dispatcher dut (
      .clk(clk), .rst_n(rst_n),
      .data_i(data_i), .valid_i(valid_i),
      .sel_i(sel_i), .key_i(key_i),
      .ready_o(ready_o),
      .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o),
      .eng_key_o(eng_key_o),
      .eng_busy_i(eng_busy_i), .eng_data_i(eng_data_i),
      .eng_valid_i(eng_valid_i),
      .data_o(data_o), .valid_o(valid_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int         cyc;
      logic [2:0] oh;
      logic [7:0] d;
   } eng_ev_t;

   typedef struct {
      int         cyc;
      logic [7:0] d;
   } out_ev_t;

   typedef struct {
      logic [7:0]  d;
      logic [1:0]  sel;
      logic [15:0] key;
      logic        rdy;
      logic [2:0]  oh;
      logic [15:0] kexp;
   } vec_t;

   eng_ev_t engq[$];
   out_ev_t outq[$];
   int      errq[$];
   vec_t    tv[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare DUT outputs against the scoreboards mid-cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (engq.size() != 0 && engq[0].cyc == cyc) begin
            eng_ev_t e;
            e = engq.pop_front();
            chk("eng_valid_o", 32'(eng_valid_o), 32'(e.oh));
            chk("eng_data_o", 32'(eng_data_o), 32'(e.d));
         end else if (eng_valid_o != 3'b000) begin
            chk("eng_strobe_unexpected", 32'(eng_valid_o), 32'd0);
         end
         if (outq.size() != 0 && outq[0].cyc == cyc) begin
            out_ev_t o;
            o = outq.pop_front();
            chk("valid_o", 32'(valid_o), 32'd1);
            chk("data_o", 32'(data_o), 32'(o.d));
         end else if (valid_o) begin
            chk("valid_o_unexpected", 32'(valid_o), 32'd0);
         end
         if (errq.size() != 0 && errq[0] == cyc) begin
            void'(errq.pop_front());
            chk("err_o", 32'(err_o), 32'd1);
         end else if (err_o) begin
            chk("err_o_unexpected", 32'(err_o), 32'd0);
         end
      end
   end

   task automatic add_msg(input string s, input logic [1:0] sel,
                          input logic [15:0] key, input logic [15:0] kexp);
      for (int i = 0; i < s.len(); i++) begin
         vec_t v;
         v.d    = s[i];
         v.sel  = sel;
         v.key  = key;
         v.rdy  = 1'b1;
         v.oh   = 3'b100;
         v.kexp = kexp;
         tv.push_back(v);
      end
   endtask

   task automatic apply(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         valid_i = 1'b1;
         data_i  = tv[i].d;
         sel_i   = tv[i].sel;
         key_i   = tv[i].key;
         chk($sformatf("ready_vec%0d", i), 32'(ready_o), 32'(tv[i].rdy));
         if (tv[i].rdy)
            engq.push_back('{cyc + 1, tv[i].oh, tv[i].d});
         step();
         chk($sformatf("key_vec%0d", i), 32'(eng_key_o), 32'(tv[i].kexp));
         chk($sformatf("busy_vec%0d", i), 32'(busy_o), 32'd1);
      end
      valid_i = 1'b0;
      chk("ready_after_token", 32'(ready_o), 32'd0);
   endtask

   task automatic run_engine(input int e, input string pt, input bit stray);
      logic [2:0] oh;
      oh = 3'(3'b001 << e);
      eng_busy_i = oh;
      step();
      valid_i = 1'b1;
      data_i  = 8'h33;
      for (int i = 0; i < pt.len(); i++) begin
         eng_valid_i = oh;
         eng_data_i  = '0;
         eng_data_i[e*8 +: 8] = pt[i];
         outq.push_back('{cyc + 1, pt[i]});
         chk("ready_in_decrypt", 32'(ready_o), 32'd0);
         chk("busy_in_decrypt", 32'(busy_o), 32'd1);
         step();
      end
      valid_i = 1'b0;
      if (stray) begin
         eng_valid_i = 3'b001;
         eng_data_i  = 24'h000099;
         errq.push_back(cyc + 1);
         step();
         chk("stray_valid_o", 32'(valid_o), 32'd0);
         eng_valid_i = 3'b101;
         eng_data_i  = 24'h210077;
         outq.push_back('{cyc + 1, 8'h21});
         errq.push_back(cyc + 1);
         step();
      end
      eng_valid_i = 3'b000;
      eng_busy_i  = 3'b000;
      step();
      chk("ready_after_busy", 32'(ready_o), 32'd1);
      chk("idle_busy_o", 32'(busy_o), 32'd0);
   endtask

   initial begin
      int m1_hi;
      int m2_hi;
      rst_n       = 1'b0;
      data_i      = 8'h00;
      valid_i     = 1'b0;
      sel_i       = 2'd0;
      key_i       = 16'h0000;
      eng_busy_i  = 3'b000;
      eng_data_i  = '0;
      eng_valid_i = 3'b000;

      add_msg("HOLELWRDLO", 2'd2, 16'h0003, 16'h0003);
      add_msg("\xFA", 2'd2, 16'h0003, 16'h0003);
      m1_hi = tv.size() - 1;
      add_msg("AB", 2'd2, 16'h1234, 16'h1234);
      add_msg("CD", 2'd0, 16'hFFFF, 16'h1234);
      add_msg("\xFA", 2'd0, 16'hFFFF, 16'h1234);
      m2_hi = tv.size() - 1;

      step();
      step();
      chk("rst_ready_o", 32'(ready_o), 32'd1);
      chk("rst_eng_valid_o", 32'(eng_valid_o), 32'd0);
      chk("rst_eng_data_o", 32'(eng_data_o), 32'd0);
      chk("rst_data_o", 32'(data_o), 32'd0);
      chk("rst_busy_o", 32'(busy_o), 32'd0);
      chk("rst_err_o", 32'(err_o), 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      step();

      apply(0, m1_hi);
      run_engine(2, "HELLOWORLD", 1'b1);

      apply(m1_hi + 1, m2_hi);
      run_engine(2, "OK", 1'b0);

      for (int i = 0; i < 50; i++) begin
         valid_i = 1'b1;
         data_i  = 8'(8'h41 + (i % 26));
         sel_i   = 2'd1;
         key_i   = 16'h0005;
         chk("ovf_ready", 32'(ready_o), 32'd1);
         engq.push_back('{cyc + 1, 3'b010, data_i});
         step();
      end
      chk("ovf_ready_inject", 32'(ready_o), 32'd0);
      engq.push_back('{cyc + 1, 3'b010, 8'hFA});
      data_i = 8'h5A;
      step();
      valid_i = 1'b0;
      chk("ovf_ready_wait", 32'(ready_o), 32'd0);
      run_engine(1, "Z", 1'b0);

      valid_i = 1'b1;
      sel_i   = 2'd3;
      data_i  = 8'h55;
      errq.push_back(cyc + 1);
      step();
      valid_i = 1'b0;
      chk("badsel_ready", 32'(ready_o), 32'd1);
      chk("badsel_busy", 32'(busy_o), 32'd0);

      valid_i = 1'b1;
      sel_i   = 2'd0;
      key_i   = 16'h0007;
      data_i  = 8'hFA;
      engq.push_back('{cyc + 1, 3'b001, 8'hFA});
      step();
      valid_i = 1'b0;
      errq.push_back(cyc + 4);
      for (int i = 0; i < 4; i++) begin
         chk("tmo_waiting", 32'(busy_o), 32'd1);
         step();
      end
      chk("tmo_idle_ready", 32'(ready_o), 32'd1);
      chk("tmo_idle_busy", 32'(busy_o), 32'd0);

      for (int i = 0; i < 5; i++) begin
         valid_i = 1'b1;
         sel_i   = 2'd2;
         key_i   = 16'h0009;
         data_i  = 8'(8'h61 + i);
         engq.push_back('{cyc + 1, 3'b100, data_i});
         step();
      end
      rst_n  = 1'b0;
      data_i = 8'h66;
      step();
      rst_n   = 1'b1;
      valid_i = 1'b0;
      chk("mid_rst_ready", 32'(ready_o), 32'd1);
      chk("mid_rst_eng_valid", 32'(eng_valid_o), 32'd0);
      chk("mid_rst_eng_data", 32'(eng_data_o), 32'd0);
      chk("mid_rst_key", 32'(eng_key_o), 32'd0);
      chk("mid_rst_data_o", 32'(data_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      step();

      valid_i = 1'b1;
      sel_i   = 2'd1;
      key_i   = 16'h0042;
      data_i  = 8'h58;
      engq.push_back('{cyc + 1, 3'b010, 8'h58});
      step();
      data_i  = 8'hFA;
      sel_i   = 2'd2;
      engq.push_back('{cyc + 1, 3'b010, 8'hFA});
      step();
      valid_i = 1'b0;
      chk("post_rst_key", 32'(eng_key_o), 32'h0042);
      run_engine(1, "Q", 1'b0);

      step();
      step();
      chk("engq_drained", 32'(engq.size()), 32'd0);
      chk("outq_drained", 32'(outq.size()), 32'd0);
      chk("errq_drained", 32'(errq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decryption_dispatcher.md
# decryption_dispatcher

Front-end controller that sequences the three decryption engines (Caesar = 0, Scytale = 1, Zigzag = 2) behind one shared input byte stream and one shared output stream. Per message it latches the engine select and key, forwards the bytes to the selected engine up to its start token, and holds off new input while that engine is busy. It then multiplexes that engine's output onto the shared output. It sits between the serial input front-end and the engine instances in the decryption top level.

## Interface
- D_WIDTH, 8, byte width
- KEY_WIDTH, 16, key width; engines use the low bits they need
- MAX_NOF_CHARS, 50, maximum payload bytes per message, excluding the token
- START_DECRYPTION_TOKEN, 8'hFA, end-of-payload / start-decryption marker
- START_TIMEOUT, 4, cycles allowed for the selected engine to raise busy after the token is forwarded

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- data_i  in  D_WIDTH  input byte
- valid_i  in  1  input byte strobe
- sel_i  in  2  engine select, sampled on the first byte of a message
- key_i  in  KEY_WIDTH  key, sampled with sel_i
- ready_o  out  1  dispatcher accepts input this cycle
- eng_data_o  out  D_WIDTH  byte to engines, shared
- eng_valid_o  out  3  one-hot strobe, bit = engine index
- eng_key_o  out  KEY_WIDTH  latched key, shared
- eng_busy_i  in  3  engine busy flags
- eng_data_i  in  3*D_WIDTH  engine outputs; engine n at [n*D_WIDTH +: D_WIDTH]
- eng_valid_i  in  3  engine output strobes
- data_o  out  D_WIDTH  muxed plaintext byte
- valid_o  out  1  plaintext strobe
- busy_o  out  1  high whenever state != IDLE
- err_o  out  1  one-cycle error pulse

## Operation
- FSM states: IDLE, LOAD, WAIT_START, DECRYPT.
- ready_o = 1 in IDLE and LOAD; 0 in WAIT_START and DECRYPT.
- IDLE:
  - valid_i with sel_i in 0..2: latch sel and key, forward the byte, then go to LOAD, or to WAIT_START if the byte is the token (empty message).
  - valid_i with sel_i = 3: drop the byte, pulse err_o, stay in IDLE.
- LOAD:
  - Each valid_i byte is forwarded to the latched engine only; sel_i and key_i are ignored.
  - A payload counter (6 bits) increments per non-token byte.
  - The token is forwarded, then the FSM goes to WAIT_START.
  - If the counter reaches MAX_NOF_CHARS, the dispatcher injects the token itself on the next cycle (eng_data_o = token) and goes to WAIT_START. valid_i is ignored during the injection cycle because ready_o is low.
- WAIT_START:
  - eng_busy_i[sel] high goes to DECRYPT.
  - If it stays low for START_TIMEOUT cycles: pulse err_o and go to IDLE.
- DECRYPT:
  - eng_busy_i[sel] low (sampled) goes to IDLE; clear the counter.
- Output mux:
  - Active in all states.
  - eng_valid_i[sel] registers eng_data_i of the latched engine to data_o and asserts valid_o.
  - eng_valid_i of a non-selected engine is ignored and pulses err_o.
- valid_i while ready_o = 0 is dropped silently.
- eng_key_o holds the latched value from the first byte until the FSM returns to IDLE.
- Reset values:
  - ready_o = 1; all other outputs = 0, including eng_valid_o = 3'b000 and data_o = 0.
  - State = IDLE; sel, key and counter cleared.
  - Reset mid-message aborts with no further engine strobes.

## Timing
- Input to engine: a byte accepted at cycle N appears on eng_data_o/eng_valid_o at N+1. This is one registered stage.
- Token accepted at N: forwarded at N+1, state = WAIT_START and ready_o = 0 from N+1.
- Engine output: eng_valid_i at M gives data_o/valid_o at M+1. Output latency stays 1 even in the cycle the FSM returns to IDLE.
- DECRYPT to IDLE: busy seen low at cycle B gives ready_o = 1 at B+1. A byte presented at B+1 is accepted.
- Back-to-back bytes are accepted every cycle in LOAD with no bubbles.
- Simultaneous err sources are ORed into one pulse.

## Test plan
- Zigzag, key 3: sel = 2, bytes "HOLELWRDLO" then FA, 1 byte/cycle. Expect eng_valid_o = 3'b100 for 11 strobes, each one cycle after input. ready_o falls the cycle after FA. data_o carries the Zigzag engine's bytes one cycle late. ready_o returns the cycle after busy drops.
- Select lock: sel_i toggles to 0 mid-message. Expect all strobes still on bit 2 and eng_key_o unchanged.
- Overflow: 50 payload bytes with no token. Expect the injected FA at cycle 51 and ready_o low from then on.
- Invalid select / timeout: sel = 3 gives a dropped byte and err_o high for 1 cycle. A token with the engine never raising busy gives err_o 4 cycles later, then IDLE.
- Reset mid-LOAD: rst_n low after 5 bytes. Expect all outputs at reset values the next cycle, and a new message accepted afterwards.
- Stray output: eng_valid_i[0] pulses while sel = 2. Expect err_o pulse and valid_o stays 0.
